// File: rtl/layernorm_pkg.sv
// Shared Q8.8 definitions for the LayerNorm datapath stages.
package layernorm_pkg;
    localparam int DW   = 16;
    localparam int FRAC = 8;

    localparam logic [DW-1:0] Q88_MAX = 16'h7FFF;
    localparam logic [DW-1:0] Q88_MIN = 16'h8000;

    typedef logic signed [DW-1:0] q88_t;

    typedef enum logic [1:0] {
        FILL,
        CALC,
        DRAIN
    } state_t;
endpackage

// File: rtl/sat_sub_q88.sv
// Combinational signed subtract a - b with one guard bit, saturated back to DW bits.
module sat_sub_q88 #(
    parameter int DW = layernorm_pkg::DW
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output logic signed [DW-1:0] o_y
);
    logic signed [DW:0] w_diff;

    // Guard bit differing from the sign bit means the true result left the DW range.
    function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
        if (v[DW] != v[DW-1])
            sat = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat = v[DW-1:0];
    endfunction

    assign w_diff = (DW+1)'(i_a) - (DW+1)'(i_b);
    assign o_y    = sat(w_diff);
endmodule

// File: rtl/mean_center_stream.sv
// Buffers one N-sample Q8.8 vector, computes its floor mean, then streams out
// each sample minus the mean with saturation.
module mean_center_stream
    import layernorm_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = layernorm_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic signed [DW-1:0] mean_out
);
    localparam int LGN = $clog2(N);
    localparam int SW  = DW + LGN;

    state_t                r_state;
    state_t                w_next;
    logic signed [DW-1:0]  r_buf [N];
    logic signed [SW-1:0]  r_sum;
    logic signed [DW-1:0]  r_mean;
    logic [LGN-1:0]        r_wr_idx;
    logic [LGN-1:0]        r_rd_idx;
    logic                  r_in_en;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic signed [DW-1:0]  w_centered;

    // r_in_en keeps in_ready low while reset is held and releases it one edge later.
    assign in_ready  = r_in_en && (r_state == FILL);
    assign out_valid = (r_state == DRAIN);
    assign out_last  = (r_state == DRAIN) && (r_rd_idx == LGN'(N-1));
    assign out_data  = (r_state == DRAIN) ? w_centered : '0;
    assign mean_out  = r_mean;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;

    sat_sub_q88 #(.DW(DW)) u_sat_sub (
        .i_a (r_buf[r_rd_idx]),
        .i_b (r_mean),
        .o_y (w_centered)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_in_hs && (r_wr_idx == LGN'(N-1))) w_next = CALC;
            CALC:    w_next = DRAIN;
            DRAIN:   if (w_out_hs && (r_rd_idx == LGN'(N-1))) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FILL;
            r_in_en  <= 1'b0;
            r_sum    <= '0;
            r_mean   <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else begin
            r_state <= w_next;
            r_in_en <= 1'b1;
            if (w_in_hs) begin
                r_sum    <= r_sum + SW'(in_data);
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            // Arithmetic shift floors toward -inf; the mean of DW-bit samples fits in DW.
            if (r_state == CALC) begin
                r_mean   <= DW'(r_sum >>> LGN);
                r_sum    <= '0;
                r_wr_idx <= '0;
                r_rd_idx <= '0;
            end
            if (w_out_hs)
                r_rd_idx <= r_rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs)
            r_buf[r_wr_idx] <= in_data;
    end
endmodule

// File: tb/tb_mean_center_stream.sv
// Scoreboard bench for mean_center_stream: directed Q8.8 vectors, backpressure,
// mid-fill reset and randomized back-to-back traffic.
module tb_mean_center_stream;
    import layernorm_pkg::*;

    localparam int N = 4;

    typedef logic [15:0] vec_t [N];
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [15:0] mean;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] mean_out;

    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    exp_t sb[$];

    mean_center_stream #(.N(N), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mean_out  (mean_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // out_ready: 0 = always ready, 1 = random, otherwise held low
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: consumes on handshake, checks hold while stalled
    initial begin
        exp_t        e;
        logic        stall;
        logic [15:0] p_data;
        logic        p_last;
        stall = 1'b0;
        p_data = '0;
        p_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, p_data);
                    chk("hold_last", out_last, p_last);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_out", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_last", out_last, e.last);
                        chk("mean_out", mean_out, e.mean);
                    end
                end
                stall  = out_valid && !out_ready;
                p_data = out_data;
                p_last = out_last;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic push_exp(input vec_t d, input logic [15:0] m);
        for (int i = 0; i < N; i++)
            sb.push_back('{data: d[i], last: (i == N-1), mean: m});
    endtask

    task automatic model_push(input vec_t v);
        int          s;
        int          m;
        int          d;
        logic [31:0] w;
        logic [31:0] mw;
        s = 0;
        for (int i = 0; i < N; i++) s += int'($signed(v[i]));
        m  = s >>> $clog2(N);
        mw = m;
        for (int i = 0; i < N; i++) begin
            d = int'($signed(v[i])) - m;
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            w = d;
            sb.push_back('{data: w[15:0], last: (i == N-1), mean: mw[15:0]});
        end
    endtask

    task automatic send_one(input logic [15:0] x, input int gap);
        int cnt;
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = x;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            if (cnt > 500) begin
                $display("FAIL in_ready_timeout checks=%0d", n_checks);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t v, input int gap, input bit lat);
        for (int i = 0; i < N; i++) send_one(v[i], gap);
        if (lat) begin
            @(negedge clk);
            chk("lat_calc_out_valid", out_valid, 0);
            chk("lat_calc_in_ready", in_ready, 0);
            @(negedge clk);
            chk("lat_drain_out_valid", out_valid, 1);
        end
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        vec_t        s1, s2, s3, s4, o1, o2, o3, o4, rv;
        logic [15:0] cap_d, cap_m;
        logic        cap_l;

        s1 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        o1 = '{16'hFE80, 16'hFF80, 16'h0080, 16'h0180};
        s2 = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        o2 = '{16'h0000, 16'h0001, 16'h0001, 16'h0001};
        s3 = '{Q88_MAX, Q88_MIN, Q88_MIN, Q88_MIN};
        o3 = '{16'h7FFF, 16'hC001, 16'hC001, 16'hC001};
        s4 = '{Q88_MIN, Q88_MAX, Q88_MAX, Q88_MAX};
        o4 = '{16'h8000, 16'h4000, 16'h4000, 16'h4000};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mean_out", mean_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        push_exp(o1, 16'h0280);
        send_vec(s1, 0, 1);
        push_exp(o2, 16'hFFFF);
        send_vec(s2, 0, 0);
        push_exp(o3, 16'hBFFF);
        send_vec(s3, 0, 0);
        push_exp(o4, 16'h3FFF);
        send_vec(s4, 0, 0);

        // Stall the second output of this vector for three edges
        wait_drain("drain_directed");
        push_exp(o1, 16'h0280);
        send_vec(s1, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy_mode = 2;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(negedge clk);
        cap_d = out_data;
        cap_l = out_last;
        cap_m = mean_out;
        chk("bp_second_data", cap_d, 16'hFF80);
        repeat (2) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, cap_d);
            chk("bp_out_last", out_last, cap_l);
            chk("bp_mean_out", mean_out, cap_m);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        rdy_mode = 0;
        in_valid = 1'b0;
        wait_drain("drain_backpressure");

        chk("mean_hold_after_drain", mean_out, 16'h0280);
        send_one(16'h0500, 0);
        send_one(16'h0500, 0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mean_out", mean_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(o1, 16'h0280);
        send_vec(s1, 0, 0);
        wait_drain("drain_after_reset");

        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       rv[i] = Q88_MAX;
                    1:       rv[i] = Q88_MIN;
                    default: rv[i] = 16'($urandom);
                endcase
            end
            model_push(rv);
            send_vec(rv, 3, 0);
        end
        wait_drain("drain_random");
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mean_center_stream.md
# mean_center_stream

Streaming mean-subtraction stage for the LayerNorm datapath, Q8.8 fixed point. Accepts one N-element vector serially over a valid/ready input port, buffers it while accumulating the sum, then forms the mean. It then emits each element minus the mean (saturated) over a valid/ready output port, with the mean on a side output. It sits downstream of the vector source and feeds the variance/normalize stage with zero-centered data.

## Interface
- N, 4: vector length; power of two, ≥2.
- DW, 16: sample width, signed Q8.8.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  DW  signed Q8.8 sample.
- out_valid  output  1  centered sample valid.
- out_ready  input  1  downstream accepts sample.
- out_data  output  DW  signed Q8.8, in_data[i] − mean, saturated.
- out_last  output  1  high with the N-th output sample of a vector.
- mean_out  output  DW  registered mean of the current vector; valid while in DRAIN.

## Operation
- States: FILL, CALC, DRAIN. Reset state FILL.
- FILL: in_ready=1. Each input handshake (in_valid && in_ready) writes in_data to buf[wr_idx], adds the sign-extended sample to sum, and increments wr_idx. Handshake with wr_idx==N−1 → CALC.
- CALC, exactly one cycle: in_ready=0, out_valid=0. mean_out ← (sum >>> log2(N))[DW−1:0], arithmetic shift, i.e. floor toward −∞. The result always fits in DW. sum cleared, wr_idx←0, rd_idx←0 → DRAIN.
- DRAIN: in_ready=0, out_valid=1. out_data = sat(buf[rd_idx] − mean_out), a combinational function of registered state only. On out_valid && out_ready, rd_idx increments. Handshake with rd_idx==N−1 → FILL.
- out_last = (state==DRAIN) && (rd_idx==N−1).
- Arithmetic: sum width DW+log2(N) bits, signed. Difference computed in DW+1 bits. Saturation: >0x7FFF → 0x7FFF; <0x8000 → 0x8000.
- No overlap: the next vector is not accepted until the current one is fully drained.

## Timing
- Reset values: in_ready=0 while rst is asserted, 1 from the first cycle after deassertion. out_valid=0, out_last=0, out_data=0, mean_out=0, sum=0, indices=0, state=FILL.
- Latency: last input handshake at cycle t → CALC at t+1 → out_valid=1 at t+2.
- Throughput: one vector per 2N+1 cycles with no backpressure.
- Backpressure: while out_valid && !out_ready, out_data, out_last and mean_out are held stable. out_valid does not drop before its handshake.
- in_valid while in_ready=0 is ignored, with no state change. Upstream holds the sample.
- Reset mid-operation, in any state: partial vector discarded, block returns to FILL with cleared sum and indices. No stale output after reset.
- mean_out holds its value after DRAIN until the next CALC overwrites it.

## Structure
- Shared package layernorm_pkg: DW and FRAC=8 constants, Q8.8 max/min saturation constants (0x7FFF/0x8000), q88_t typedef, and the state enum (FILL, CALC, DRAIN).
- One sub-module, sat_sub_q88: combinational (a − b) in DW+1 bits, saturated to DW. Instantiated once on the output path.
- Top level holds the FSM, buffer array, accumulator, mean register and both indices.

## Test plan
- N=4, inputs 0x0100,0x0200,0x0300,0x0400 → mean_out=0x0280. Outputs 0xFE80,0xFF80,0x0080,0x0180, with out_last on the 4th. First out_valid 2 cycles after the last input handshake.
- Inputs 0xFFFF,0,0,0 → sum=−1, mean_out=0xFFFF (floor). Outputs 0x0000,0x0001,0x0001,0x0001.
- Saturation, both directions:
  - Inputs 0x7FFF,0x8000,0x8000,0x8000 → mean_out=0xBFFF. Outputs 0x7FFF (saturated), then 0xC001 ×3.
  - Inputs 0x8000,0x7FFF,0x7FFF,0x7FFF → mean_out=0x3FFF. Outputs 0x8000 (saturated), then 0x4000 ×3.
- Backpressure: hold out_ready=0 for 3 cycles on the 2nd output → out_data/out_last stable, no sample lost or duplicated. in_valid pulses during DRAIN are ignored.
- Reset mid-fill: accept 0x0500,0x0500, assert rst, then send the vector from the first scenario → outputs identical to the first scenario. Back-to-back vectors with random in_valid gaps match a scoreboard model.
